// File: rtl/demux_deser_1to4.sv
// Serial-to-parallel deserializer: steers each accepted bit to lane bit_idx (LSB-first)
// and offers completed words downstream through a one-entry valid/ready holding register.
module demux_deser_1to4 #(
   parameter int WIDTH = 4,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             frame_start,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic [IDX_W-1:0] bit_idx,
   output logic             overrun,
   input  logic             ovr_clr
);

   localparam logic [0:0]       ST_EMPTY = 1'b0;
   localparam logic [0:0]       ST_FULL  = 1'b1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   logic [WIDTH-1:0] partial;
   logic [WIDTH-1:0] word;
   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic             complete;
   logic             load;
   logic             ovr_evt;

   function automatic logic [WIDTH-1:0] set_lane(input logic [WIDTH-1:0] w,
                                                 input logic [IDX_W-1:0] idx,
                                                 input logic             b);
      logic [WIDTH-1:0] r;
      r      = w;
      r[idx] = b;
      return r;
   endfunction

   // A realign on the final-index cycle restarts the word instead of completing it.
   assign complete   = bit_valid & ~frame_start & (bit_idx == LAST_IDX);
   assign word       = set_lane(partial, LAST_IDX, bit_in);
   assign data_valid = (state == ST_FULL);

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      ovr_evt   = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (complete) begin
               load      = 1'b1;
               state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (complete) begin
               if (data_ready) load    = 1'b1;
               else            ovr_evt = 1'b1;
            end else if (data_ready) begin
               state_nxt = ST_EMPTY;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   // Collect stage: lane steering and bit-index counter
   always_ff @(posedge clk) begin
      if (rst) begin
         partial <= '0;
         bit_idx <= '0;
      end else if (frame_start) begin
         partial <= bit_valid ? {{(WIDTH-1){1'b0}}, bit_in} : '0;
         bit_idx <= bit_valid ? IDX_W'(1) : '0;
      end else if (bit_valid) begin
         partial <= complete ? '0 : set_lane(partial, bit_idx, bit_in);
         bit_idx <= bit_idx + IDX_W'(1);
      end
   end

   // Output stage: holding register and sticky overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_EMPTY;
         data_out <= '0;
         overrun  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) data_out <= word;
         if (ovr_evt)      overrun <= 1'b1;
         else if (ovr_clr) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_demux_deser_1to4.sv
// Bench for demux_deser_1to4: directed vector table, hand-written corner sequences,
// then random traffic checked against a queue-based reference model.
module tb_demux_deser_1to4;

   localparam int WIDTH = 4;
   localparam int IDX_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             bit_in = 1'b0;
   logic             bit_valid = 1'b0;
   logic             frame_start = 1'b0;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             data_ready = 1'b0;
   logic [IDX_W-1:0] bit_idx;
   logic             overrun;
   logic             ovr_clr = 1'b0;

   int checks = 0;
   int errors = 0;

   demux_deser_1to4 #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
      .frame_start(frame_start), .data_out(data_out), .data_valid(data_valid),
      .data_ready(data_ready), .bit_idx(bit_idx), .overrun(overrun), .ovr_clr(ovr_clr)
   );

   always #5 clk = ~clk;

   // Reference model: bits since last word/realign, plus one-entry output slot
   bit m_bits[$];
   bit [WIDTH-1:0] m_word;
   bit m_valid;
   bit m_ovr;

   task automatic model_step(input bit r, bv, bi, fs, rdy, clr);
      bit done;
      bit evt;
      bit [WIDTH-1:0] nw;
      done = 0;
      evt  = 0;
      nw   = '0;
      if (r) begin
         m_bits.delete();
         m_word  = '0;
         m_valid = 0;
         m_ovr   = 0;
         return;
      end
      if (fs) begin
         m_bits.delete();
         if (bv) m_bits.push_back(bi);
      end else if (bv) begin
         m_bits.push_back(bi);
         if (m_bits.size() == WIDTH) begin
            for (int i = 0; i < WIDTH; i++) nw[i] = m_bits[i];
            m_bits.delete();
            done = 1;
         end
      end
      if (m_valid && rdy) m_valid = 0;
      if (done) begin
         if (!m_valid) begin
            m_word  = nw;
            m_valid = 1;
         end else begin
            evt = 1;
         end
      end
      if (evt)      m_ovr = 1;
      else if (clr) m_ovr = 0;
   endtask

   task automatic drive(input bit r, bv, bi, fs, rdy, clr);
      @(negedge clk);
      rst = r; bit_valid = bv; bit_in = bi; frame_start = fs; data_ready = rdy; ovr_clr = clr;
      model_step(r, bv, bi, fs, rdy, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input int ev, ed, ei, eo);
      chk({tag, ".valid"},   int'(data_valid), ev);
      chk({tag, ".data"},    int'(data_out),   ed);
      chk({tag, ".idx"},     int'(bit_idx),    ei);
      chk({tag, ".overrun"}, int'(overrun),    eo);
   endtask

   task automatic step(input string tag, input bit r, bv, bi, fs, rdy, clr,
                       input int ev, ed, ei, eo);
      drive(r, bv, bi, fs, rdy, clr);
      chk_all(tag, ev, ed, ei, eo);
   endtask

   typedef struct {
      bit r, bv, bi, fs, rdy, clr;
      int ev, ed, ei, eo;
   } vec_t;

   vec_t vecs[16];

   initial begin
      // r  bv bi fs rdy clr | valid data     idx ovr
      vecs[0]  = '{1, 0, 0, 0, 1, 0, 0, 0,       0, 0};
      vecs[1]  = '{0, 1, 1, 0, 1, 0, 0, 0,       1, 0};
      vecs[2]  = '{0, 1, 0, 0, 1, 0, 0, 0,       2, 0};
      vecs[3]  = '{0, 1, 1, 0, 1, 0, 0, 0,       3, 0};
      vecs[4]  = '{0, 1, 1, 0, 1, 0, 1, 4'b1101, 0, 0};
      vecs[5]  = '{0, 0, 0, 0, 1, 0, 0, 4'b1101, 0, 0};
      vecs[6]  = '{0, 1, 0, 0, 0, 0, 0, 4'b1101, 1, 0};
      vecs[7]  = '{0, 1, 1, 0, 0, 0, 0, 4'b1101, 2, 0};
      vecs[8]  = '{0, 1, 0, 0, 0, 0, 0, 4'b1101, 3, 0};
      vecs[9]  = '{0, 1, 1, 0, 0, 0, 1, 4'b1010, 0, 0};
      vecs[10] = '{0, 1, 1, 0, 0, 0, 1, 4'b1010, 1, 0};
      vecs[11] = '{0, 1, 1, 0, 0, 0, 1, 4'b1010, 2, 0};
      vecs[12] = '{0, 1, 0, 0, 0, 0, 1, 4'b1010, 3, 0};
      vecs[13] = '{0, 1, 0, 0, 0, 0, 1, 4'b1010, 0, 1};
      vecs[14] = '{0, 0, 0, 0, 0, 1, 1, 4'b1010, 0, 0};
      vecs[15] = '{0, 0, 0, 0, 1, 0, 0, 4'b1010, 0, 0};

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].r, vecs[i].bv, vecs[i].bi, vecs[i].fs, vecs[i].rdy, vecs[i].clr);
         chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ei, vecs[i].eo);
      end

      // Gapped input: index advances only on valid cycles
      step("gap0", 0, 1, 0, 0, 1, 0, 0, 4'b1010, 1, 0);
      step("gap1", 0, 0, 1, 0, 1, 0, 0, 4'b1010, 1, 0);
      step("gap2", 0, 1, 1, 0, 1, 0, 0, 4'b1010, 2, 0);
      step("gap3", 0, 0, 0, 0, 1, 0, 0, 4'b1010, 2, 0);
      step("gap4", 0, 1, 1, 0, 1, 0, 0, 4'b1010, 3, 0);
      step("gap5", 0, 0, 1, 0, 1, 0, 0, 4'b1010, 3, 0);
      step("gap6", 0, 1, 0, 0, 1, 0, 1, 4'b0110, 0, 0);

      // Simultaneous consume and complete keeps data_valid high without overrun
      step("sim_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 1, 0, 0, 0);
      chk_all("sim_full", 1, 4'b1111, 0, 0);
      step("sim_b0", 0, 1, 1, 0, 0, 0, 1, 4'b1111, 1, 0);
      step("sim_b1", 0, 1, 0, 0, 0, 0, 1, 4'b1111, 2, 0);
      step("sim_b2", 0, 1, 0, 0, 0, 0, 1, 4'b1111, 3, 0);
      step("sim_b3", 0, 1, 0, 0, 1, 0, 1, 4'b0001, 0, 0);
      step("sim_drain", 0, 0, 0, 0, 1, 0, 0, 4'b0001, 0, 0);

      // frame_start realign, with and without a valid bit
      step("fs_b0", 0, 1, 1, 0, 1, 0, 0, 4'b0001, 1, 0);
      step("fs_b1", 0, 1, 1, 0, 1, 0, 0, 4'b0001, 2, 0);
      step("fs_re", 0, 1, 0, 1, 1, 0, 0, 4'b0001, 1, 0);
      step("fs_b2", 0, 1, 1, 0, 1, 0, 0, 4'b0001, 2, 0);
      step("fs_b3", 0, 1, 0, 0, 1, 0, 0, 4'b0001, 3, 0);
      step("fs_b4", 0, 1, 0, 0, 1, 0, 1, 4'b0010, 0, 0);
      step("fs_b5", 0, 1, 1, 0, 1, 0, 0, 4'b0010, 1, 0);
      step("fs_nov", 0, 0, 0, 1, 1, 0, 0, 4'b0010, 0, 0);
      // Realign on the last index must not complete a word
      step("fs_l0", 0, 1, 1, 0, 1, 0, 0, 4'b0010, 1, 0);
      step("fs_l1", 0, 1, 1, 0, 1, 0, 0, 4'b0010, 2, 0);
      step("fs_l2", 0, 1, 1, 0, 1, 0, 0, 4'b0010, 3, 0);
      step("fs_l3", 0, 1, 1, 1, 1, 0, 0, 4'b0010, 1, 0);

      // Reset mid-word while FULL with overrun pending
      step("rm_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, (i != 1), 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0);
      chk_all("rm_pre", 1, 4'b1101, 3, 1);
      step("rm_hit", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      step("rm_c0", 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      step("rm_c1", 0, 1, 1, 0, 0, 0, 0, 0, 2, 0);
      step("rm_c2", 0, 1, 1, 0, 0, 0, 0, 0, 3, 0);
      step("rm_c3", 0, 1, 0, 0, 0, 0, 1, 4'b0110, 0, 0);

      // Overrun set and clear in the same cycle: set wins
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0);
      step("ovr_both", 0, 1, 0, 0, 0, 1, 1, 4'b0110, 0, 1);

      // Random traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         bit r, bv, bi, fs, rdy, clr;
         r   = ($urandom_range(0, 199) == 0);
         bv  = ($urandom_range(0, 9) < 7);
         bi  = 1'($urandom);
         fs  = ($urandom_range(0, 15) == 0);
         rdy = ($urandom_range(0, 9) < 4);
         clr = ($urandom_range(0, 9) == 0);
         drive(r, bv, bi, fs, rdy, clr);
         chk_all($sformatf("rnd%0d", n), int'(m_valid), int'(m_word),
                 m_bits.size(), int'(m_ovr));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
